// File: rtl/mii_phy_if_if.sv
// mii_phy_if_if: 8-bit AXI-stream bundle (data, valid, ready, last, user) with master/slave views
interface mii_phy_if_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;
    modport master(output tdata, tvalid, tlast, tuser, input tready);
    modport slave(input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/mii_phy_if.sv
// mii_phy_if: PHY-side MII endpoint; stream-to-MII-rx generator and MII-tx-to-stream checker
module mii_phy_if #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_NIBBLES  = 24
) (
    input  logic         clk,
    input  logic         rst,
    mii_phy_if_if.slave  s_axis,
    mii_phy_if_if.master m_axis,
    output logic [3:0]   mii_rxd,
    output logic         mii_rx_dv,
    output logic         mii_rx_er,
    input  logic [3:0]   mii_txd,
    input  logic         mii_tx_en,
    input  logic         mii_tx_er,
    output logic         gen_underflow,
    output logic         chk_bad_frame
);
    localparam logic [2:0] G_IDLE = 3'd0;
    localparam logic [2:0] G_PRE  = 3'd1;
    localparam logic [2:0] G_SFD  = 3'd2;
    localparam logic [2:0] G_DLO  = 3'd3;
    localparam logic [2:0] G_DHI  = 3'd4;
    localparam logic [2:0] G_UND  = 3'd5;
    localparam logic [2:0] G_DROP = 3'd6;
    localparam logic [2:0] G_IFG  = 3'd7;
    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_PRE  = 2'd1;
    localparam logic [1:0] C_DATA = 2'd2;
    localparam logic [1:0] C_WAIT = 2'd3;
    // PRE covers the preamble plus the 0x5 half of the SFD; the 0xD half is its own state
    localparam logic [7:0] PRE_END = 8'(2 * PREAMBLE_LEN);
    // IDLE supplies the final gap cycle, so IFG itself lasts one cycle less
    localparam logic [7:0] IFG_END = 8'(IFG_NIBBLES - 2);
    localparam logic [2:0] G_AFTER = (IFG_NIBBLES == 1) ? G_IDLE : G_IFG;

    logic [2:0] gst_q, gst_d;
    logic [7:0] gcnt_q, gcnt_d;
    logic [7:0] byte_q, byte_d;
    logic       last_q, last_d;
    logic       user_q, user_d;

    logic [1:0] cst_q, cst_d;
    logic       half_q, half_d;
    logic [3:0] lo_q, lo_d;
    logic [7:0] hold_q, hold_d;
    logic       have_q, have_d;
    logic       err_q, err_d;
    logic [7:0] tdata_q, tdata_d;
    logic       tvalid_q, tvalid_d;
    logic       tlast_q, tlast_d;
    logic       tuser_q, tuser_d;
    logic       bad_q, bad_d;

    // Generator: next state, MII rx drive and s_axis ready, all decoded from the current state
    always_comb begin
        gst_d = gst_q;
        gcnt_d = gcnt_q + 8'd1;
        byte_d = byte_q;
        last_d = last_q;
        user_d = user_q;
        s_axis.tready = 1'b0;
        mii_rxd = 4'h0;
        mii_rx_dv = 1'b0;
        mii_rx_er = 1'b0;
        gen_underflow = 1'b0;
        case (gst_q)
            G_IDLE: begin
                gcnt_d = 8'd0;
                if (s_axis.tvalid) gst_d = G_PRE;
            end
            G_PRE: begin
                mii_rxd = 4'h5;
                mii_rx_dv = 1'b1;
                if (gcnt_q == PRE_END) gst_d = G_SFD;
            end
            G_SFD: begin
                mii_rxd = 4'hd;
                mii_rx_dv = 1'b1;
                s_axis.tready = 1'b1;
                gst_d = s_axis.tvalid ? G_DLO : G_UND;
            end
            G_DLO: begin
                mii_rxd = byte_q[3:0];
                mii_rx_dv = 1'b1;
                mii_rx_er = last_q & user_q;
                gst_d = G_DHI;
            end
            G_DHI: begin
                mii_rxd = byte_q[7:4];
                mii_rx_dv = 1'b1;
                mii_rx_er = last_q & user_q;
                s_axis.tready = ~last_q;
                gcnt_d = 8'd0;
                gst_d = last_q ? G_AFTER : (s_axis.tvalid ? G_DLO : G_UND);
            end
            G_UND: begin
                mii_rx_dv = 1'b1;
                mii_rx_er = 1'b1;
                gen_underflow = 1'b1;
                s_axis.tready = 1'b1;
                gcnt_d = 8'd0;
                gst_d = (s_axis.tvalid && s_axis.tlast) ? G_AFTER : G_DROP;
            end
            G_DROP: begin
                s_axis.tready = 1'b1;
                gcnt_d = 8'd0;
                if (s_axis.tvalid && s_axis.tlast) gst_d = G_AFTER;
            end
            default: begin
                if (gcnt_q == IFG_END) gst_d = G_IDLE;
            end
        endcase
        if (s_axis.tvalid && s_axis.tready && (gst_q == G_SFD || gst_q == G_DHI)) begin
            byte_d = s_axis.tdata;
            last_d = s_axis.tlast;
            user_d = s_axis.tuser;
        end
    end

    // Generator state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gst_q <= G_IDLE;
            gcnt_q <= 8'd0;
            byte_q <= 8'd0;
            last_q <= 1'b0;
            user_q <= 1'b0;
        end else begin
            gst_q <= gst_d;
            gcnt_q <= gcnt_d;
            byte_q <= byte_d;
            last_q <= last_d;
            user_q <= user_d;
        end
    end

    // Checker: parse preamble/SFD, pair nibbles into bytes, hold one byte back so tlast can ride on it
    always_comb begin
        cst_d = cst_q;
        half_d = half_q;
        lo_d = lo_q;
        hold_d = hold_q;
        have_d = have_q;
        err_d = err_q;
        tdata_d = tdata_q;
        tvalid_d = 1'b0;
        tlast_d = 1'b0;
        tuser_d = 1'b0;
        bad_d = 1'b0;
        case (cst_q)
            C_IDLE: begin
                if (mii_tx_en) begin
                    cst_d = (mii_txd == 4'h5) ? C_PRE : C_WAIT;
                    bad_d = mii_txd != 4'h5;
                end
            end
            C_PRE: begin
                if (mii_tx_en && mii_txd == 4'hd) begin
                    cst_d = C_DATA;
                    half_d = 1'b0;
                    have_d = 1'b0;
                    err_d = 1'b0;
                end else if (!mii_tx_en || mii_txd != 4'h5) begin
                    cst_d = mii_tx_en ? C_WAIT : C_IDLE;
                    bad_d = 1'b1;
                end
            end
            C_DATA: begin
                if (mii_tx_en) begin
                    err_d = err_q | mii_tx_er;
                    half_d = ~half_q;
                    lo_d = half_q ? lo_q : mii_txd;
                    if (half_q) begin
                        hold_d = {mii_txd, lo_q};
                        have_d = 1'b1;
                        tvalid_d = have_q;
                        tdata_d = hold_q;
                    end
                end else begin
                    cst_d = C_IDLE;
                    tvalid_d = have_q;
                    tlast_d = have_q;
                    tdata_d = hold_q;
                    tuser_d = have_q & (err_q | half_q);
                    bad_d = ~have_q | err_q | half_q;
                    have_d = 1'b0;
                end
            end
            default: begin
                if (!mii_tx_en) cst_d = C_IDLE;
            end
        endcase
    end

    // Checker state and registered m_axis outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cst_q <= C_IDLE;
            half_q <= 1'b0;
            lo_q <= 4'h0;
            hold_q <= 8'd0;
            have_q <= 1'b0;
            err_q <= 1'b0;
            tdata_q <= 8'd0;
            tvalid_q <= 1'b0;
            tlast_q <= 1'b0;
            tuser_q <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            cst_q <= cst_d;
            half_q <= half_d;
            lo_q <= lo_d;
            hold_q <= hold_d;
            have_q <= have_d;
            err_q <= err_d;
            tdata_q <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q <= tlast_d;
            tuser_q <= tuser_d;
            bad_q <= bad_d;
        end
    end

    assign m_axis.tdata = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast = tlast_q;
    assign m_axis.tuser = tuser_q;
    assign chk_bad_frame = bad_q;
endmodule

// File: tb/tb_mii_phy_if.sv
// tb_mii_phy_if: scoreboard bench for mii_phy_if (generator via loopback into checker, plus MAC-driven frames)
module tb_mii_phy_if;
    localparam int P = 7;
    localparam int IFG = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mii_phy_if_if s_if ();
    mii_phy_if_if m_if ();

    logic [3:0] rxd, txd, tb_txd;
    logic rx_dv, rx_er, tx_en, tx_er, tb_tx_en, tb_tx_er, loop, und, bad;

    assign txd   = loop ? rxd : tb_txd;
    assign tx_en = loop ? rx_dv : tb_tx_en;
    assign tx_er = loop ? rx_er : tb_tx_er;
    assign m_if.tready = 1'b1;

    mii_phy_if #(.PREAMBLE_LEN(P), .IFG_NIBBLES(IFG)) dut (
        .clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if),
        .mii_rxd(rxd), .mii_rx_dv(rx_dv), .mii_rx_er(rx_er),
        .mii_txd(txd), .mii_tx_en(tx_en), .mii_tx_er(tx_er),
        .gen_underflow(und), .chk_bad_frame(bad)
    );

    int vectors = 0;
    int errors = 0;

    typedef struct packed {logic [3:0] d; logic er; logic un;} nib_t;
    typedef struct packed {logic bad_only; logic [7:0] d; logic last; logic user;} ev_t;
    nib_t exp_nib[$];
    ev_t  exp_ev[$];
    int runs[$];
    int gaps[$];
    int run_len = 0;
    int low_len = 0;
    bit seen_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: got unexpected event, expected none", name);
    endtask

    // Stream the MAC should see for a run of data nibbles: bytes pair low-then-high, error if odd or flagged
    function automatic void expect_rx(input logic [3:0] nibs[$], input bit any_er);
        int nb = nibs.size() / 2;
        bit err = any_er || (nibs.size() % 2 != 0);
        if (nb == 0) exp_ev.push_back({1'b1, 8'h00, 1'b0, 1'b0});
        for (int k = 0; k < nb; k++)
            exp_ev.push_back({1'b0, nibs[2*k+1], nibs[2*k], k == nb - 1, (k == nb - 1) && err});
    endfunction

    // MAC-side frame parse: leading 0x5s, then 0xD, then data; anything else is a bad frame
    function automatic void model_mac(input logic [3:0] nib[$], input int er_at);
        int i = 1;
        logic [3:0] data[$];
        if (nib.size() == 0) return;
        if (nib[0] != 4'h5) begin
            exp_ev.push_back({1'b1, 8'h00, 1'b0, 1'b0});
            return;
        end
        while (i < nib.size() && nib[i] == 4'h5) i++;
        if (i == nib.size() || nib[i] != 4'hd) begin
            exp_ev.push_back({1'b1, 8'h00, 1'b0, 1'b0});
            return;
        end
        for (int k = i + 1; k < nib.size(); k++) data.push_back(nib[k]);
        expect_rx(data, er_at > i);
    endfunction

    task automatic wait_ready();
        int g = 0;
        bit hs;
        do begin
            hs = s_if.tready;
            @(negedge clk);
            g++;
        end while (!hs && g < 2000);
        if (!hs) fail_now("tready_timeout");
    endtask

    task automatic gen_frame(input int n, input bit user, input int hole, input bit ramp);
        logic [7:0] b[$];
        logic [3:0] dn[$];
        int nb;
        for (int k = 0; k < n; k++) b.push_back(ramp ? 8'(k) : 8'($urandom));
        for (int k = 0; k < 2 * P + 1; k++) exp_nib.push_back({4'h5, 2'b00});
        exp_nib.push_back({4'hd, 2'b00});
        nb = (hole >= 0) ? hole : n;
        for (int k = 0; k < nb; k++) begin
            logic er;
            er = user && (k == n - 1);
            exp_nib.push_back({b[k][3:0], er, 1'b0});
            exp_nib.push_back({b[k][7:4], er, 1'b0});
            dn.push_back(b[k][3:0]);
            dn.push_back(b[k][7:4]);
        end
        if (hole >= 0) begin
            exp_nib.push_back({4'h0, 2'b11});
            dn.push_back(4'h0);
        end
        expect_rx(dn, user || hole >= 0);
        for (int k = 0; k < n; k++) begin
            if (k == hole) begin
                s_if.tvalid = 1'b0;
                wait_ready();
            end
            s_if.tdata = b[k];
            s_if.tlast = (k == n - 1);
            s_if.tuser = user && (k == n - 1);
            s_if.tvalid = 1'b1;
            wait_ready();
        end
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
        s_if.tuser = 1'b0;
    endtask

    task automatic mac_send(input logic [3:0] nib[$], input int er_at);
        model_mac(nib, er_at);
        for (int k = 0; k < nib.size(); k++) begin
            tb_tx_en = 1'b1;
            tb_txd = nib[k];
            tb_tx_er = (k == er_at);
            @(negedge clk);
        end
        tb_tx_en = 1'b0;
        tb_tx_er = 1'b0;
        tb_txd = 4'h0;
        repeat (3) @(negedge clk);
    endtask

    task automatic build(input int plen, input int dlen, output logic [3:0] q[$]);
        q = {};
        for (int k = 0; k < plen; k++) q.push_back(4'h5);
        q.push_back(4'hd);
        for (int k = 0; k < dlen; k++) q.push_back(4'($urandom));
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_nib.size() != 0 || exp_ev.size() != 0) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        repeat (40) @(negedge clk);
        check("queues_drained", exp_nib.size() + exp_ev.size(), 0);
    endtask

    // Generator monitor: every rx_dv nibble is popped against the model; also logs run and gap lengths
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_dv) begin
                if (exp_nib.size() == 0) fail_now("gen_extra_nibble");
                else begin
                    nib_t e;
                    e = exp_nib.pop_front();
                    check("gen_nibble", {rxd, rx_er, und}, {e.d, e.er, e.un});
                end
                if (run_len == 0 && seen_run) gaps.push_back(low_len);
                run_len++;
                low_len = 0;
            end else begin
                if (rx_er || und) fail_now("gen_idle_er_or_underflow");
                if (run_len > 0) begin
                    runs.push_back(run_len);
                    seen_run = 1;
                end
                run_len = 0;
                low_len++;
            end
        end
    end

    // Checker monitor: each m_axis beat or lone bad-frame pulse pops one expected event
    always @(negedge clk) begin
        if (!rst) begin
            if (m_if.tvalid) begin
                if (exp_ev.size() == 0) fail_now("chk_extra_beat");
                else begin
                    ev_t e;
                    e = exp_ev.pop_front();
                    check("chk_beat", {1'b0, m_if.tdata, m_if.tlast, m_if.tuser, bad},
                          {e.bad_only, e.d, e.last, e.user, e.last & e.user});
                end
            end else if (bad) begin
                if (exp_ev.size() == 0) fail_now("chk_extra_bad");
                else begin
                    ev_t e;
                    e = exp_ev.pop_front();
                    check("chk_bad_only", {1'b1, bad}, {e.bad_only, 1'b1});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] q[$];
        s_if.tvalid = 1'b0;
        s_if.tdata = 8'h00;
        s_if.tlast = 1'b0;
        s_if.tuser = 1'b0;
        tb_tx_en = 1'b0;
        tb_tx_er = 1'b0;
        tb_txd = 4'h0;
        loop = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tready", s_if.tready, 0);
        check("rst_rx_dv", rx_dv, 0);
        check("rst_rx_er", rx_er, 0);
        check("rst_rxd", rxd, 0);
        check("rst_m_tvalid", m_if.tvalid, 0);
        check("rst_m_tlast", m_if.tlast, 0);
        check("rst_m_tuser", m_if.tuser, 0);
        check("rst_m_tdata", m_if.tdata, 0);
        check("rst_underflow", und, 0);
        check("rst_bad", bad, 0);
        rst = 1'b0;
        @(negedge clk);

        gen_frame(60, 1'b0, -1, 1'b1);
        drain();
        check("run_len_60", runs.size() ? runs[runs.size()-1] : -1, 2 * P + 2 + 120);

        gen_frame(64, 1'b0, -1, 1'b0);
        gen_frame(64, 1'b0, -1, 1'b0);
        drain();
        check("ifg_gap", gaps.size() ? gaps[gaps.size()-1] : -1, IFG);
        check("run_len_64", runs.size() ? runs[runs.size()-1] : -1, 2 * P + 2 + 128);

        gen_frame(64, 1'b0, 11, 1'b0);
        drain();
        check("run_len_underflow", runs.size() ? runs[runs.size()-1] : -1, 2 * P + 2 + 22 + 1);

        gen_frame(64, 1'b1, -1, 1'b0);
        drain();

        for (int r = 0; r < 8; r++) begin
            int n, hole;
            n = $urandom_range(1, 20);
            hole = (n > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
            gen_frame(n, 1'($urandom_range(0, 1)), hole, 1'b0);
        end
        drain();

        loop = 1'b0;
        @(negedge clk);
        build(15, 9, q);
        mac_send(q, -1);
        q = {4'h5, 4'h5, 4'h7};
        mac_send(q, -1);
        build(15, 16, q);
        mac_send(q, -1);
        q = {4'h5, 4'h5, 4'hd};
        mac_send(q, -1);
        q = {4'h3, 4'h5, 4'hd};
        mac_send(q, -1);
        for (int r = 0; r < 8; r++) begin
            int plen, dlen;
            plen = $urandom_range(1, 15);
            dlen = $urandom_range(0, 30);
            build(plen, dlen, q);
            mac_send(q, ($urandom_range(0, 1) == 1) ? $urandom_range(0, plen + dlen) : -1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
